// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   DEFAULT_WIDTH : default operand/result width
//   state_e       : controller state encoding (IDLE, RUN, DONE)
package serial_adder_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Launch/result handshake bundle for serial_adder_ctrl.
//   start, a, b, cin (, sub) : launch request and operands (master -> slave)
//   busy, done, sum, cout    : status and registered result (slave -> master)
// Optional macro SERIAL_ADDER_SUB_EN adds the 1-bit sub request.
interface serial_adder_ctrl_if
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell shared by the serial adder datapath.
//   a, b, cin : addend bits and carry-in
//   sum, cout : sum bit and carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder cell plus a carry flop
// sequenced over WIDTH bits, LSB first. A result takes WIDTH RUN cycles,
// followed by a one-cycle done pulse.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_adder_ctrl_if (start/a/b/cin in,
//           busy/done/sum/cout out)
// Optional macro SERIAL_ADDER_SUB_EN: bus.sub=1 computes a - b by loading
// ~b and a forced carry-in of 1; cout=1 then means no borrow.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);

  localparam int unsigned    CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc_sr;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_q),
    .sum  (fa_s),
    .cout (fa_c)
  );

  // Shifting through the concatenation keeps this valid for WIDTH=1,
  // where the accumulator is just the current sum bit.
  always_comb begin
    acc_next = WIDTH'({fa_s, acc_sr} >> 1);
  end

`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    b_load = bus.sub ? ~bus.b : bus.b;
    c_load = bus.sub ? 1'b1 : bus.cin;
  end
`else
  always_comb begin
    b_load = bus.b;
    c_load = bus.cin;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      acc_sr   <= '0;
      carry_q  <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_sr     <= bus.a;
            b_sr     <= b_load;
            carry_q  <= c_load;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc_sr  <= acc_next;
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          carry_q <= fa_c;
          cnt     <= cnt + 1'b1;
          // Result registers take the accumulator including this cycle's bit.
          if (cnt == LAST) begin
            bus.sum  <= acc_next;
            bus.cout <= fa_c;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=4 instances).
// A transaction-level model predicts busy/done/sum/cout from operand
// arithmetic and a WIDTH-cycle latency; every cycle is compared, and
// directed cases also check hand-computed literal results.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(4)) bus4 ();

  serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  logic s8, s4;
`ifdef SERIAL_ADDER_SUB_EN
  assign s8 = bus8.sub;
  assign s4 = bus4.sub;
`else
  assign s8 = 1'b0;
  assign s4 = 1'b0;
`endif

  // Full (w+1)-bit result of a + b + cin, or a + ~b + 1 when subtracting.
  function automatic logic [32:0] ref_add(int unsigned w, logic [31:0] a,
                                          logic [31:0] b, logic c, logic s);
    logic [32:0] mask, bb, r;
    mask = (33'd1 << w) - 33'd1;
    bb   = s ? ((~{1'b0, b}) & mask) : {1'b0, b};
    r    = {1'b0, a} + bb + (s ? 33'd1 : {32'd0, c});
    return r;
  endfunction

  // Transaction model: remaining busy cycles, then a one-cycle done.
  int         m8_rem = 0,  m4_rem = 0;
  logic       m8_done = 1'b0, m4_done = 1'b0;
  logic [7:0] m8_sum = '0;
  logic [3:0] m4_sum = '0;
  logic       m8_cout = 1'b0, m4_cout = 1'b0;
  logic [8:0] m8_res = '0;
  logic [4:0] m4_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8_rem <= 0; m8_done <= 1'b0; m8_sum <= '0; m8_cout <= 1'b0;
    end else if (m8_done) begin
      m8_done <= 1'b0;
    end else if (m8_rem != 0) begin
      m8_rem <= m8_rem - 1;
      if (m8_rem == 1) begin
        m8_done <= 1'b1;
        m8_sum  <= m8_res[7:0];
        m8_cout <= m8_res[8];
      end
    end else if (bus8.start) begin
      m8_rem <= 8;
      m8_res <= 9'(ref_add(8, 32'(bus8.a), 32'(bus8.b), bus8.cin, s8));
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4_rem <= 0; m4_done <= 1'b0; m4_sum <= '0; m4_cout <= 1'b0;
    end else if (m4_done) begin
      m4_done <= 1'b0;
    end else if (m4_rem != 0) begin
      m4_rem <= m4_rem - 1;
      if (m4_rem == 1) begin
        m4_done <= 1'b1;
        m4_sum  <= m4_res[3:0];
        m4_cout <= m4_res[4];
      end
    end else if (bus4.start) begin
      m4_rem <= 4;
      m4_res <= 5'(ref_add(4, 32'(bus4.a), 32'(bus4.b), bus4.cin, s4));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle and compare both DUTs against the model.
  task automatic tick();
    @(negedge clk);
    chk("busy8", 32'(bus8.busy), 32'(m8_rem != 0));
    chk("done8", 32'(bus8.done), 32'(m8_done));
    chk("sum8",  32'(bus8.sum),  32'(m8_sum));
    chk("cout8", 32'(bus8.cout), 32'(m8_cout));
    chk("busy4", 32'(bus4.busy), 32'(m4_rem != 0));
    chk("done4", 32'(bus4.done), 32'(m4_done));
    chk("sum4",  32'(bus4.sum),  32'(m4_sum));
    chk("cout4", 32'(bus4.cout), 32'(m4_cout));
  endtask

  // One 8-bit operation with literal expectations; optional stray start
  // pulse at RUN cycle poke_at (0 = none). Ends back in IDLE.
  task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic s, input logic [7:0] exp_sum,
                      input logic exp_cout, input logic [7:0] prev_sum, input int poke_at);
    int n;
    bus8.a = a; bus8.b = b; bus8.cin = c;
`ifdef SERIAL_ADDER_SUB_EN
    bus8.sub = s;
`else
    if (s) $display("note: sub requested without SERIAL_ADDER_SUB_EN");
`endif
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    bus8.a = ~a; bus8.b = ~b; bus8.cin = ~c;
    n = 0;
    while (n < 20) begin
      if (poke_at != 0 && n == poke_at) begin
        bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01;
      end else begin
        bus8.start = 1'b0;
      end
      tick();
      n++;
      if (bus8.done) break;
      chk({name, "_hold"}, 32'(bus8.sum), 32'(prev_sum));
    end
    bus8.start = 1'b0;
    chk({name, "_lat"},  n, 8);
    chk({name, "_sum"},  32'(bus8.sum), 32'(exp_sum));
    chk({name, "_cout"}, 32'(bus8.cout), 32'(exp_cout));
    tick();
  endtask

  initial begin
    int t1, t2, n;
    logic [4:0] e4;
    rst_n = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus8.sub = 1'b0; bus4.sub = 1'b0;
`endif
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Idle after reset
    repeat (20) tick();
    chk("idle_busy", 32'(bus8.busy), 0);
    chk("idle_done", 32'(bus8.done), 0);
    chk("idle_sum",  32'(bus8.sum),  0);
    chk("idle_cout", 32'(bus8.cout), 0);

    run8("add12_34",  8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 8'h00, 0);
    run8("addFF_01",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 8'h46, 0);
    run8("addA5_5A",  8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 0);
    run8("ignore",    8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 8'h00, 3);

    // start held high: back-to-back results every WIDTH+2 cycles
    bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0; bus8.start = 1'b1;
    t1 = -1; t2 = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus8.done) begin
        if (t1 < 0) t1 = i;
        else begin t2 = i; break; end
      end
    end
    bus8.start = 1'b0;
    chk("b2b_gap", t2 - t1, 10);
    chk("b2b_sum", 32'(bus8.sum), 32'h30);
    tick(); tick();

    // Reset in RUN cycle 4
    bus8.a = 8'h0F; bus8.b = 8'h01; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus8.busy), 0);
    chk("arst_done", 32'(bus8.done), 0);
    chk("arst_sum",  32'(bus8.sum),  0);
    chk("arst_cout", 32'(bus8.cout), 0);
    tick();
    rst_n = 1'b1;
    tick();
    run8("post_rst", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 8'h00, 0);

`ifdef SERIAL_ADDER_SUB_EN
    run8("sub05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 8'h10, 0);
    run8("sub07_05", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 8'hFE, 0);
    bus8.sub = 1'b0;
`endif

    // Exhaustive WIDTH=4
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          bus4.a = 4'(a); bus4.b = 4'(b); bus4.cin = c[0]; bus4.start = 1'b1;
          tick();
          bus4.start = 1'b0;
          n = 0;
          while (n < 10) begin
            tick();
            n++;
            if (bus4.done) break;
          end
          e4 = 5'(a + b + c);
          chk("w4_lat", n, 4);
          chk("w4_res", 32'({bus4.cout, bus4.sum}), 32'(e4));
          tick();
        end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
